encode_instr_emitter: RTL and testbench

Byte-serial x86 instruction encoder and the inverse of the opcode decode path. It accepts one structured instruction record (prefixes, optional 0x0F escape, opcode, ModRM, SIB, displacement, immediate) over a valid/ready handshake. It then emits the architectural byte stream one byte per cycle over a second valid/ready handshake. It also publishes the 88-bit unescaped instruction image in the layout the decoder consumes, so benches and trace generators can close the loop encode → decode.

---
 rtl/encode_instr_emitter.sv | 202 ++++++++++++++++++++
 tb/tb_encode_instr_emitter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/encode_instr_emitter.sv
// rtl/encode_instr_emitter.sv - byte-serial x86 instruction encoder with unescaped image output
module encode_instr_emitter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  prefix_cnt,
    input  logic [31:0] prefixes,
    input  logic        is_2byte,
    input  logic [7:0]  opc_byte,
    input  logic        has_modrm,
    input  logic [7:0]  modrm,
    input  logic        has_sib,
    input  logic [7:0]  sib,
    input  logic [2:0]  disp_len,
    input  logic [31:0] disp,
    input  logic [2:0]  imm_len,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [3:0]  instr_len,
    output logic [87:0] unescaped_instr,
    output logic        err
);
    typedef enum logic [3:0] {IDLE, PREFIX, ESCAPE, OPC, MODRM, SIB, DISP, IMM, ERR} state_t;

    typedef struct packed {
        logic [2:0]  pcnt;
        logic [31:0] pref;
        logic        esc;
        logic [7:0]  opc;
        logic        hm;
        logic [7:0]  modrm;
        logic        hs;
        logic [7:0]  sib;
        logic [2:0]  dlen;
        logic [31:0] disp;
        logic [2:0]  ilen;
        logic [31:0] imm;
    } rec_t;

    state_t      state, next_state;
    logic [2:0]  cnt, next_cnt;
    rec_t        in_rec, r_rec, s_rec;
    logic        accept, adv, legal, emit, nxt_last;
    logic [4:0]  len5;
    logic [7:0]  nxt_byte;
    logic [87:0] img;

    // Field state that follows s; IDLE means the instruction ends after s.
    function automatic state_t next_field(state_t s, rec_t r);
        state_t tail;
        tail = (r.dlen != 3'd0) ? DISP : ((r.ilen != 3'd0) ? IMM : IDLE);
        case (s)
            IDLE:    next_field = (r.pcnt != 3'd0) ? PREFIX : (r.esc ? ESCAPE : OPC);
            PREFIX:  next_field = r.esc ? ESCAPE : OPC;
            ESCAPE:  next_field = OPC;
            OPC:     next_field = r.hm ? MODRM : tail;
            MODRM:   next_field = r.hs ? SIB : tail;
            SIB:     next_field = tail;
            DISP:    next_field = (r.ilen != 3'd0) ? IMM : IDLE;
            default: next_field = IDLE;
        endcase
    endfunction

    function automatic logic [2:0] fld_len(state_t s, rec_t r);
        case (s)
            PREFIX:  fld_len = r.pcnt;
            DISP:    fld_len = r.dlen;
            IMM:     fld_len = r.ilen;
            default: fld_len = 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] pick(logic [31:0] w, logic [2:0] idx);
        logic [31:0] sh;
        sh = w >> {idx[1:0], 3'b000};
        return sh[7:0];
    endfunction

    function automatic logic [7:0] byte_of(state_t s, logic [2:0] idx, rec_t r);
        case (s)
            PREFIX:  byte_of = pick(r.pref, idx);
            ESCAPE:  byte_of = 8'h0F;
            OPC:     byte_of = r.opc;
            MODRM:   byte_of = r.modrm;
            SIB:     byte_of = r.sib;
            DISP:    byte_of = pick(r.disp, idx);
            IMM:     byte_of = pick(r.imm, idx);
            default: byte_of = 8'h00;
        endcase
    endfunction

    function automatic logic ok_len(logic [2:0] l);
        return (l == 3'd0) || (l == 3'd1) || (l == 3'd2) || (l == 3'd4);
    endfunction

    assign in_rec = '{pcnt: prefix_cnt, pref: prefixes, esc: is_2byte, opc: opc_byte,
                      hm: has_modrm, modrm: modrm, hs: has_sib, sib: sib,
                      dlen: disp_len, disp: disp, ilen: imm_len, imm: imm};
    assign accept = in_valid & in_ready;
    assign adv    = out_valid & out_ready;
    // On the acceptance cycle the first byte comes straight from the inputs.
    assign s_rec  = accept ? in_rec : r_rec;

    assign len5  = 5'(in_rec.pcnt) + 5'(in_rec.esc) + 5'd1 + 5'(in_rec.hm) + 5'(in_rec.hs)
                 + 5'(in_rec.dlen) + 5'(in_rec.ilen);
    assign legal = (in_rec.pcnt <= 3'd4) && ok_len(in_rec.dlen) && ok_len(in_rec.ilen)
                 && !(in_rec.hs && !in_rec.hm) && (len5 <= 5'd15);

    always_comb begin : img_build
        int p;
        img = 88'(in_rec.opc);
        p   = 1;
        if (in_rec.hm) begin
            img = img | (88'(in_rec.modrm) << (8 * p));
            p   = p + 1;
        end
        if (in_rec.hs) begin
            img = img | (88'(in_rec.sib) << (8 * p));
            p   = p + 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (i < int'(in_rec.dlen)) begin
                img = img | (88'(in_rec.disp[8*i +: 8]) << (8 * p));
                p   = p + 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < int'(in_rec.ilen)) begin
                img = img | (88'(in_rec.imm[8*i +: 8]) << (8 * p));
                p   = p + 1;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_cnt   = 3'd0;
                    next_state = legal ? next_field(IDLE, in_rec) : ERR;
                end
            end
            ERR: next_state = IDLE;
            default: begin
                if (adv) begin
                    if ((cnt + 3'd1) < fld_len(state, s_rec)) begin
                        next_cnt = cnt + 3'd1;
                    end else begin
                        next_state = next_field(state, s_rec);
                        next_cnt   = 3'd0;
                    end
                end
            end
        endcase
        emit     = (next_state != IDLE) && (next_state != ERR);
        nxt_byte = byte_of(next_state, next_cnt, s_rec);
        nxt_last = (next_field(next_state, s_rec) == IDLE)
                 && ((next_cnt + 3'd1) == fld_len(next_state, s_rec));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rec           <= '0;
            in_ready        <= 1'b1;
            out_valid       <= 1'b0;
            out_byte        <= 8'h00;
            out_last        <= 1'b0;
            err             <= 1'b0;
            instr_len       <= 4'd0;
            unescaped_instr <= 88'd0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= emit;
            out_byte  <= emit ? nxt_byte : 8'h00;
            out_last  <= emit & nxt_last;
            err       <= (next_state == ERR);
            if (accept) begin
                r_rec <= in_rec;
            end
            if (accept && legal) begin
                instr_len       <= len5[3:0];
                unescaped_instr <= img;
            end
        end
    end
endmodule

// File: tb/tb_encode_instr_emitter.sv
// tb/tb_encode_instr_emitter.sv - directed-vector bench for encode_instr_emitter
module tb_encode_instr_emitter;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  prefix_cnt;
    logic [31:0] prefixes;
    logic        is_2byte;
    logic [7:0]  opc_byte;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [2:0]  disp_len;
    logic [31:0] disp;
    logic [2:0]  imm_len;
    logic [31:0] imm;
    logic        out_valid, out_ready, out_last, err;
    logic [7:0]  out_byte;
    logic [3:0]  instr_len;
    logic [87:0] unescaped_instr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_b [16];

    always #5 clk = ~clk;

    encode_instr_emitter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .prefix_cnt(prefix_cnt), .prefixes(prefixes), .is_2byte(is_2byte),
        .opc_byte(opc_byte), .has_modrm(has_modrm), .modrm(modrm),
        .has_sib(has_sib), .sib(sib), .disp_len(disp_len), .disp(disp),
        .imm_len(imm_len), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last), .instr_len(instr_len),
        .unescaped_instr(unescaped_instr), .err(err)
    );

    task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        prefix_cnt = 3'd0; prefixes = 32'd0; is_2byte = 1'b0; opc_byte = 8'h00;
        has_modrm = 1'b0; modrm = 8'h00; has_sib = 1'b0; sib = 8'h00;
        disp_len = 3'd0; disp = 32'd0; imm_len = 3'd0; imm = 32'd0;
    endtask

    // Present the record for one edge, then scramble fields to prove they were captured.
    task automatic send();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opc_byte = 8'hEE; modrm = 8'hEE; sib = 8'hEE; disp = 32'hEEEEEEEE; imm = 32'hEEEEEEEE;
        prefixes = 32'hEEEEEEEE;
    endtask

    task automatic expect_bytes(input string tag, input int n, input int stall_at);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_b%0d", tag, i), 88'({out_valid, out_last, out_byte}),
                  88'({1'b1, (i == n - 1), exp_b[i]}));
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check($sformatf("%s_hold%0d", tag, k), 88'({out_valid, out_last, out_byte}),
                          88'({1'b1, (i == n - 1), exp_b[i]}));
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        check({tag, "_done"}, 88'({in_ready, out_valid}), 88'(2'b10));
    endtask

    task automatic expect_err(input string tag, input logic [3:0] keep_len);
        send();
        check({tag, "_n1"}, 88'({err, out_valid, in_ready}), 88'(3'b100));
        @(posedge clk); #1;
        check({tag, "_n2"}, 88'({err, out_valid, in_ready}), 88'(3'b001));
        check({tag, "_len"}, 88'(instr_len), 88'(keep_len));
    endtask

    task automatic load_mov();
        clear_rec();
        opc_byte = 8'h8B; has_modrm = 1'b1; modrm = 8'h84; has_sib = 1'b1; sib = 8'h8B;
        disp_len = 3'd4; disp = 32'h12345678;
        exp_b[0] = 8'h8B; exp_b[1] = 8'h84; exp_b[2] = 8'h8B; exp_b[3] = 8'h78;
        exp_b[4] = 8'h56; exp_b[5] = 8'h34; exp_b[6] = 8'h12;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, 88'({in_ready, out_valid, out_last, err, out_byte}), 88'(12'h800));
        check({tag, "_len"}, 88'(instr_len), 88'd0);
        check({tag, "_img"}, unescaped_instr, 88'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        clear_rec();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        clear_rec(); opc_byte = 8'h90; exp_b[0] = 8'h90;
        send();
        expect_bytes("nop", 1, -1);
        check("nop_len", 88'(instr_len), 88'd1);
        check("nop_img", unescaped_instr, 88'h90);

        load_mov();
        send();
        expect_bytes("mov", 7, -1);
        check("mov_len", 88'(instr_len), 88'd7);
        check("mov_img", unescaped_instr, 88'h12345678_8B848B);

        clear_rec();
        prefix_cnt = 3'd1; prefixes = 32'h66; is_2byte = 1'b1; opc_byte = 8'hAF;
        has_modrm = 1'b1; modrm = 8'hC1;
        exp_b[0] = 8'h66; exp_b[1] = 8'h0F; exp_b[2] = 8'hAF; exp_b[3] = 8'hC1;
        send();
        expect_bytes("esc", 4, -1);
        check("esc_len", 88'(instr_len), 88'd4);
        check("esc_img", unescaped_instr, 88'hC1AF);

        load_mov();
        send();
        expect_bytes("bp", 7, 4);

        clear_rec();
        prefix_cnt = 3'd3; prefixes = 32'h00F02E66; is_2byte = 1'b1; opc_byte = 8'hAB;
        has_modrm = 1'b1; modrm = 8'h84; has_sib = 1'b1; sib = 8'h24;
        disp_len = 3'd4; disp = 32'h11223344; imm_len = 3'd4; imm = 32'hAABBCCDD;
        exp_b[0] = 8'h66; exp_b[1] = 8'h2E; exp_b[2] = 8'hF0; exp_b[3] = 8'h0F;
        exp_b[4] = 8'hAB; exp_b[5] = 8'h84; exp_b[6] = 8'h24; exp_b[7] = 8'h44;
        exp_b[8] = 8'h33; exp_b[9] = 8'h22; exp_b[10] = 8'h11; exp_b[11] = 8'hDD;
        exp_b[12] = 8'hCC; exp_b[13] = 8'hBB; exp_b[14] = 8'hAA;
        send();
        expect_bytes("max15", 15, -1);
        check("max15_len", 88'(instr_len), 88'd15);
        check("max15_img", unescaped_instr, 88'hAABBCCDD_11223344_2484AB);

        clear_rec(); opc_byte = 8'h90; disp_len = 3'd3;
        expect_err("ill_d3", 4'd15);
        check("ill_d3_img", unescaped_instr, 88'hAABBCCDD_11223344_2484AB);

        clear_rec();
        prefix_cnt = 3'd4; prefixes = 32'h2E3E6626; is_2byte = 1'b1; opc_byte = 8'h01;
        has_modrm = 1'b1; has_sib = 1'b1; disp_len = 3'd4; imm_len = 3'd4;
        expect_err("ill_16", 4'd15);

        clear_rec(); opc_byte = 8'h01; has_sib = 1'b1;
        expect_err("ill_sib", 4'd15);

        load_mov();
        send();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rst_mid_pre", 88'({out_valid, out_byte}), 88'({1'b1, 8'h78}));
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_quiet", 88'({out_valid, in_ready}), 88'(2'b01));
        end

        clear_rec(); opc_byte = 8'h90; exp_b[0] = 8'h90;
        send();
        expect_bytes("nop2", 1, -1);
        check("nop2_len", 88'(instr_len), 88'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
